fifo_ms_occ: RTL and testbench

//   Multi-stream (multi-flux) FIFO with one write port shared by all fluxes. Each word carries its flux
//   tag in the top bits, and each flux has its own one-hot read strobe. Each flux keeps its own ring

---
 rtl/fifo_ms_occ.sv | 183 ++++++++++++++++++
 tb/tb_fifo_ms_occ.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_ms_occ.sv
// Multi-stream FIFO: one shared tagged write port, per-flux one-hot read strobes,
// per-flux ring buffers with occupancy counts, threshold flags and sticky error flags.
module fifo_ms_occ #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned FLUX       = 2,
    parameter int unsigned AFULL_LVL  = DEPTH - 2,
    parameter int unsigned AEMPTY_LVL = 1,
    localparam int unsigned TAG_WIDTH  = $clog2(FLUX),
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
    localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1),
    localparam int unsigned WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          din,
    input  logic                      write,
    output logic [FLUX-1:0]           full,
    output logic [FLUX-1:0]           almost_full,
    input  logic [FLUX-1:0]           read,
    output logic [WIDTH-1:0]          dout,
    output logic                      dout_valid,
    output logic [FLUX-1:0]           empty,
    output logic [FLUX-1:0]           almost_empty,
    output logic [FLUX*CNT_WIDTH-1:0] count,
    output logic [FLUX-1:0]           overflow,
    output logic [FLUX-1:0]           underflow,
    output logic                      bad_tag,
    input  logic                      err_clr
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AFULL_C  = CNT_WIDTH'(AFULL_LVL);
    localparam logic [CNT_WIDTH-1:0] AEMPTY_C = CNT_WIDTH'(AEMPTY_LVL);
    localparam bit                   SPARSE_TAGS = (1 << TAG_WIDTH) != FLUX;

    logic [DATA_WIDTH-1:0] mem_q [FLUX][DEPTH];

    logic [ADDR_WIDTH-1:0] wp_q  [FLUX];
    logic [ADDR_WIDTH-1:0] wp_d  [FLUX];
    logic [ADDR_WIDTH-1:0] rp_q  [FLUX];
    logic [ADDR_WIDTH-1:0] rp_d  [FLUX];
    logic [CNT_WIDTH-1:0]  cnt_q [FLUX];
    logic [CNT_WIDTH-1:0]  cnt_d [FLUX];

    logic [FLUX-1:0]  ovf_q, ovf_d;
    logic [FLUX-1:0]  unf_q, unf_d;
    logic             bad_q, bad_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;

    logic [TAG_WIDTH-1:0]  tag_c;
    logic                  tag_ok_c;
    logic [TAG_WIDTH-1:0]  rd_sel_c;
    logic                  rd_any_c;
    logic [FLUX-1:0]       full_c;
    logic [FLUX-1:0]       empty_c;
    logic [FLUX-1:0]       wr_acc_c;
    logic [FLUX-1:0]       rd_acc_c;

    assign tag_c = din[WIDTH-1 -: TAG_WIDTH];

    // Only non-power-of-2 flux counts can present an unmapped tag.
    if (SPARSE_TAGS) begin : g_tag_chk
        assign tag_ok_c = tag_c < TAG_WIDTH'(FLUX);
    end else begin : g_tag_all
        assign tag_ok_c = 1'b1;
    end

    // Lowest set read strobe selects the flux; other bits are ignored.
    always_comb begin
        rd_any_c = 1'b0;
        rd_sel_c = '0;
        for (int unsigned f = 0; f < FLUX; f++) begin
            if (read[f] && !rd_any_c) begin
                rd_any_c = 1'b1;
                rd_sel_c = TAG_WIDTH'(f);
            end
        end
    end

    // Per-flux flags and acceptance, all judged on pre-cycle counts.
    always_comb begin
        full_c   = '0;
        empty_c  = '0;
        wr_acc_c = '0;
        rd_acc_c = '0;
        for (int unsigned f = 0; f < FLUX; f++) begin
            full_c[f]   = cnt_q[f] == DEPTH_C;
            empty_c[f]  = cnt_q[f] == '0;
            wr_acc_c[f] = write && tag_ok_c && (tag_c == TAG_WIDTH'(f)) && !full_c[f];
            rd_acc_c[f] = rd_any_c && (rd_sel_c == TAG_WIDTH'(f)) && !empty_c[f];
        end
    end

    // Next-state for pointers, counts, sticky errors and read output.
    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        ovf_d  = err_clr ? '0 : ovf_q;
        unf_d  = err_clr ? '0 : unf_q;
        bad_d  = bad_q & ~err_clr;
        dout_d = dout_q;
        dv_d   = 1'b0;

        if (write && !tag_ok_c) begin
            bad_d = 1'b1;
        end

        for (int unsigned f = 0; f < FLUX; f++) begin
            if (write && tag_ok_c && (tag_c == TAG_WIDTH'(f)) && full_c[f]) begin
                ovf_d[f] = 1'b1;
            end
            if (rd_any_c && (rd_sel_c == TAG_WIDTH'(f)) && empty_c[f]) begin
                unf_d[f] = 1'b1;
            end
            if (wr_acc_c[f]) begin
                wp_d[f] = wp_q[f] + ADDR_WIDTH'(1);
            end
            if (rd_acc_c[f]) begin
                rp_d[f] = rp_q[f] + ADDR_WIDTH'(1);
            end
            cnt_d[f] = cnt_q[f] + CNT_WIDTH'(wr_acc_c[f]) - CNT_WIDTH'(rd_acc_c[f]);
        end

        if (|rd_acc_c) begin
            dout_d = {rd_sel_c, mem_q[rd_sel_c][rp_q[rd_sel_c]]};
            dv_d   = 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (|wr_acc_c) begin
            mem_q[tag_c][wp_q[tag_c]] <= din[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned f = 0; f < FLUX; f++) begin
                wp_q[f]  <= '0;
                rp_q[f]  <= '0;
                cnt_q[f] <= '0;
            end
            ovf_q  <= '0;
            unf_q  <= '0;
            bad_q  <= 1'b0;
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            bad_q  <= bad_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
        end
    end

    always_comb begin
        count        = '0;
        almost_full  = '0;
        almost_empty = '0;
        for (int unsigned f = 0; f < FLUX; f++) begin
            count[f*CNT_WIDTH +: CNT_WIDTH] = cnt_q[f];
            almost_full[f]  = cnt_q[f] >= AFULL_C;
            almost_empty[f] = cnt_q[f] <= AEMPTY_C;
        end
    end

    assign full       = full_c;
    assign empty      = empty_c;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
    assign bad_tag    = bad_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;

endmodule

// File: tb/tb_fifo_ms_occ.sv
// Directed bench for fifo_ms_occ: a vector table for the main sequence, plus hand-written
// streaming, async-reset and unmapped-tag (3-flux instance) sequences.
module tb_fifo_ms_occ;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 2-flux instance (WIDTH=9, CNT_WIDTH=4)
    logic [8:0] din;
    logic       write;
    logic [1:0] read;
    logic       err_clr;
    logic [1:0] full, almost_full, empty, almost_empty, overflow, underflow;
    logic [8:0] dout;
    logic       dout_valid, bad_tag;
    logic [7:0] count;

    // 3-flux instance (WIDTH=10, CNT_WIDTH=4)
    logic [9:0]  din2;
    logic        write2;
    logic [2:0]  read2;
    logic        err_clr2;
    logic [2:0]  full2, almost_full2, empty2, almost_empty2, overflow2, underflow2;
    logic [9:0]  dout2;
    logic        dout_valid2, bad_tag2;
    logic [11:0] count2;

    fifo_ms_occ #(.DATA_WIDTH(8), .DEPTH(8), .FLUX(2), .AFULL_LVL(6), .AEMPTY_LVL(1)) dut (
        .clk(clk), .rst(rst), .din(din), .write(write), .full(full), .almost_full(almost_full),
        .read(read), .dout(dout), .dout_valid(dout_valid), .empty(empty),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .bad_tag(bad_tag), .err_clr(err_clr)
    );

    fifo_ms_occ #(.DATA_WIDTH(8), .DEPTH(8), .FLUX(3), .AFULL_LVL(6), .AEMPTY_LVL(1)) dut3 (
        .clk(clk), .rst(rst), .din(din2), .write(write2), .full(full2),
        .almost_full(almost_full2), .read(read2), .dout(dout2), .dout_valid(dout_valid2),
        .empty(empty2), .almost_empty(almost_empty2), .count(count2), .overflow(overflow2),
        .underflow(underflow2), .bad_tag(bad_tag2), .err_clr(err_clr2)
    );

    typedef struct {
        logic       wr;
        logic       tag;
        logic [7:0] dat;
        logic [1:0] rd;
        logic       clr;
        logic [3:0] c0;
        logic [3:0] c1;
        logic [1:0] full;
        logic [1:0] af;
        logic [1:0] em;
        logic [1:0] ae;
        logic [1:0] ovf;
        logic [1:0] unf;
        logic       dv;
        logic [8:0] dout;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];

    function automatic vec_t mk(logic wr, logic tag, logic [7:0] dat, logic [1:0] rd, logic clr,
                                logic [3:0] c0, logic [3:0] c1, logic [1:0] fl, logic [1:0] af,
                                logic [1:0] em, logic [1:0] ae, logic [1:0] ovf, logic [1:0] unf,
                                logic dv, logic [8:0] dq);
        vec_t v;
        v.wr = wr; v.tag = tag; v.dat = dat; v.rd = rd; v.clr = clr;
        v.c0 = c0; v.c1 = c1; v.full = fl; v.af = af; v.em = em; v.ae = ae;
        v.ovf = ovf; v.unf = unf; v.dv = dv; v.dout = dq;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] snap();
        return 64'({bad_tag, count, full, almost_full, empty, almost_empty,
                    overflow, underflow, dout_valid, dout});
    endfunction

    initial begin
        // Main sequence: each row is applied for one clock, then the outputs are checked.
        tbl.push_back(mk(1,0,8'hA0,2'b00,0, 1,0, 2'b00,2'b00,2'b10,2'b11, 2'b00,2'b00, 0,9'h000));
        tbl.push_back(mk(1,1,8'hB0,2'b00,0, 1,1, 2'b00,2'b00,2'b00,2'b11, 2'b00,2'b00, 0,9'h000));
        tbl.push_back(mk(1,0,8'hA1,2'b00,0, 2,1, 2'b00,2'b00,2'b00,2'b10, 2'b00,2'b00, 0,9'h000));
        tbl.push_back(mk(0,0,8'h00,2'b01,0, 1,1, 2'b00,2'b00,2'b00,2'b11, 2'b00,2'b00, 1,9'h0A0));
        tbl.push_back(mk(0,0,8'h00,2'b01,0, 0,1, 2'b00,2'b00,2'b01,2'b11, 2'b00,2'b00, 1,9'h0A1));
        tbl.push_back(mk(0,0,8'h00,2'b00,0, 0,1, 2'b00,2'b00,2'b01,2'b11, 2'b00,2'b00, 0,9'h0A1));
        tbl.push_back(mk(0,0,8'h00,2'b10,0, 0,0, 2'b00,2'b00,2'b11,2'b11, 2'b00,2'b00, 1,9'h1B0));
        for (int k = 1; k <= 8; k++) begin
            tbl.push_back(mk(1, 1, 8'(8'h0F + k), 2'b00, 0, 0, 4'(k),
                             (k == 8) ? 2'b10 : 2'b00, (k >= 6) ? 2'b10 : 2'b00,
                             2'b01, (k == 1) ? 2'b11 : 2'b01, 2'b00, 2'b00, 0, 9'h1B0));
        end
        tbl.push_back(mk(1,1,8'hFF,2'b00,0, 0,8, 2'b10,2'b10,2'b01,2'b01, 2'b10,2'b00, 0,9'h1B0));
        tbl.push_back(mk(1,0,8'hC0,2'b00,0, 1,8, 2'b10,2'b10,2'b00,2'b01, 2'b10,2'b00, 0,9'h1B0));
        tbl.push_back(mk(1,0,8'hC1,2'b00,0, 2,8, 2'b10,2'b10,2'b00,2'b00, 2'b10,2'b00, 0,9'h1B0));
        tbl.push_back(mk(1,0,8'hC2,2'b00,0, 3,8, 2'b10,2'b10,2'b00,2'b00, 2'b10,2'b00, 0,9'h1B0));
        tbl.push_back(mk(1,0,8'hC3,2'b01,0, 3,8, 2'b10,2'b10,2'b00,2'b00, 2'b10,2'b00, 1,9'h0C0));
        tbl.push_back(mk(0,0,8'h00,2'b01,0, 2,8, 2'b10,2'b10,2'b00,2'b00, 2'b10,2'b00, 1,9'h0C1));
        tbl.push_back(mk(0,0,8'h00,2'b01,0, 1,8, 2'b10,2'b10,2'b00,2'b01, 2'b10,2'b00, 1,9'h0C2));
        tbl.push_back(mk(0,0,8'h00,2'b01,0, 0,8, 2'b10,2'b10,2'b01,2'b01, 2'b10,2'b00, 1,9'h0C3));
        tbl.push_back(mk(0,0,8'h00,2'b00,1, 0,8, 2'b10,2'b10,2'b01,2'b01, 2'b00,2'b00, 0,9'h0C3));
        tbl.push_back(mk(1,1,8'hEE,2'b10,0, 0,7, 2'b00,2'b10,2'b01,2'b01, 2'b10,2'b00, 1,9'h110));
        tbl.push_back(mk(0,0,8'h00,2'b01,0, 0,7, 2'b00,2'b10,2'b01,2'b01, 2'b10,2'b01, 0,9'h110));
        tbl.push_back(mk(0,0,8'h00,2'b00,1, 0,7, 2'b00,2'b10,2'b01,2'b01, 2'b00,2'b00, 0,9'h110));
        tbl.push_back(mk(0,0,8'h00,2'b01,1, 0,7, 2'b00,2'b10,2'b01,2'b01, 2'b00,2'b01, 0,9'h110));
        tbl.push_back(mk(0,0,8'h00,2'b00,1, 0,7, 2'b00,2'b10,2'b01,2'b01, 2'b00,2'b00, 0,9'h110));
        tbl.push_back(mk(0,0,8'h00,2'b11,0, 0,7, 2'b00,2'b10,2'b01,2'b01, 2'b00,2'b01, 0,9'h110));
        tbl.push_back(mk(1,0,8'hD0,2'b00,0, 1,7, 2'b00,2'b10,2'b00,2'b01, 2'b00,2'b01, 0,9'h110));
        tbl.push_back(mk(0,0,8'h00,2'b11,0, 0,7, 2'b00,2'b10,2'b01,2'b01, 2'b00,2'b01, 1,9'h0D0));
        tbl.push_back(mk(0,0,8'h00,2'b00,1, 0,7, 2'b00,2'b10,2'b01,2'b01, 2'b00,2'b00, 0,9'h0D0));

        rst = 1'b1;
        din = '0; write = 1'b0; read = '0; err_clr = 1'b0;
        din2 = '0; write2 = 1'b0; read2 = '0; err_clr2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", snap(), 64'({1'b0, 8'h00, 2'b00, 2'b00, 2'b11, 2'b11,
                                          2'b00, 2'b00, 1'b0, 9'h000}));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            write   = tbl[k].wr;
            din     = {tbl[k].tag, tbl[k].dat};
            read    = tbl[k].rd;
            err_clr = tbl[k].clr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), snap(),
                  64'({1'b0, tbl[k].c1, tbl[k].c0, tbl[k].full, tbl[k].af, tbl[k].em, tbl[k].ae,
                       tbl[k].ovf, tbl[k].unf, tbl[k].dv, tbl[k].dout}));
        end
        write = 1'b0; read = '0; err_clr = 1'b0;

        // Write/read pairs through flux 0, wrapping the pointers more than twice.
        for (int i = 0; i <= 20; i++) begin
            write = (i < 20);
            din   = {1'b0, 8'(i)};
            read  = (i > 0) ? 2'b01 : 2'b00;
            @(posedge clk);
            #1;
            if (i > 0) begin
                check($sformatf("stream%0d", i), {dout_valid, dout}, {1'b1, 1'b0, 8'(i - 1)});
            end
        end
        write = 1'b0; read = '0;
        check("stream_end", {bad_tag, overflow, underflow, count}, {1'b0, 2'b00, 2'b00, 8'h70});

        // Reset asserted between edges with a read result on dout.
        write = 1'b1; din = {1'b0, 8'h31};
        @(posedge clk);
        #1;
        din = {1'b0, 8'h32}; read = 2'b01;
        @(posedge clk);
        #1;
        check("pre_rst", {dout_valid, dout, count}, {1'b1, 9'h031, 8'h71});
        write = 1'b0; read = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_async", snap(), 64'({1'b0, 8'h00, 2'b00, 2'b00, 2'b11, 2'b11,
                                        2'b00, 2'b00, 1'b0, 9'h000}));
        @(negedge clk);
        rst = 1'b0;

        // Unmapped tag on the 3-flux instance.
        write2 = 1'b1; din2 = {2'd3, 8'h55};
        @(posedge clk);
        #1;
        check("bad_tag_set", {bad_tag2, overflow2, count2}, {1'b1, 3'b000, 12'h000});
        din2 = {2'd2, 8'h66};
        @(posedge clk);
        #1;
        check("tag2_write", {bad_tag2, empty2, count2}, {1'b1, 3'b011, 12'h100});
        write2 = 1'b0; err_clr2 = 1'b1; read2 = 3'b100;
        @(posedge clk);
        #1;
        check("bad_tag_clr", {bad_tag2, dout_valid2, dout2, count2}, {1'b0, 1'b1, 10'h266, 12'h000});
        err_clr2 = 1'b0; read2 = '0;
        check("bad_tag_isolated", {bad_tag, count}, {1'b0, 8'h00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
